para_stat: RTL and testbench
============================

PARA_STAT -- requirements
Module: para_stat

Interface
REQ-001 Parameters (name, default, meaning): NCH, 4, channel count (1..8); DW, 16, unsigned sample width; WIN_LOG2, 8, window length = 2^WIN_LOG2 samples per channel (1..12).
REQ-002 Ports (name, direction, width, meaning):
- clk_sys, in, 1, single clock.
- rst, in, 1, reset, synchronous, active-high.
- sm_data, in, DW, sample.
- sm_ch, in, 3, channel index of sample.
- sm_vld, in, 1, sample strobe.
- fx_wr, in, 1, write strobe.
- fx_waddr, in, 22, write address.
- fx_data, in, 8, write byte.
- fx_rd, in, 1, read strobe.
- fx_raddr, in, 22, read address.
- fx_q, out, 8, read byte.
- dev_id, in, 6, device select.
REQ-003 Access decodes only when addr[21:16]==dev_id; offset = addr[7:0]; addr[15:8] ignored.

Function
REQ-004 Register map (offset, access):
- 0x00 CTRL, rw: bit0 RUN; bit1 CLR, self-clearing, reads 0.
- 0x01 STATUS, ro: bit0 RUN; bits7:4 window-done count mod 16.
- 0x02/0x03 THR lo/hi, rw.
- 0x10+8*ch+{0..7}, ro: AVE lo/hi, MIN lo/hi, MAX lo/hi, HIT lo/hi.
REQ-005 Undecoded or out-of-range offsets read 0x00; writes to them have no effect.
REQ-006 fx_q registered: valid exactly 1 cycle after fx_rd; holds its value otherwise.
REQ-007 Same-cycle fx_wr and fx_rd to one offset: read returns the pre-write value.
REQ-008 Per-channel FSM states: IDLE, ACC, DUMP.
- IDLE->ACC when RUN=1.
- ACC->DUMP on the accepted sample that makes count==2^WIN_LOG2.
- DUMP->ACC after one cycle.
- Any state->IDLE when RUN=0; the partial window is discarded.
REQ-009 A sample is accepted only if sm_vld=1, RUN=1 and sm_ch<NCH; samples with sm_ch>=NCH are dropped silently.
REQ-010 Sum width is DW+WIN_LOG2, so overflow is impossible.
REQ-011 At window end:
- AVE = sum>>WIN_LOG2 (truncate).
- MIN and MAX = unsigned extremes over the window.
- HIT = number of samples > THR, saturating at 0xFFFF.
REQ-012 Result registers update together, 1 cycle after the final sample is accepted (DUMP); between windows they hold.
REQ-013 A sample arriving during DUMP for the same channel is accepted as sample 1 of the next window; no sample is lost.
REQ-014 Reading the lo byte of any 16-bit result latches its hi byte into a shared shadow; a subsequent hi-byte read of the same field returns the shadow (tear-free); a hi-byte read without a preceding lo-byte read returns the live value.
REQ-015 CLR zeroes all accumulators, counts, results and the window-done count in the cycle after the write; RUN is kept; CLR has priority over a same-cycle window end.
REQ-016 THR changes take effect on the next accepted sample.

Reset
REQ-017 rst=1 sets all of the following to 0: CTRL, THR, all results, counters, shadow and fx_q; FSMs go to IDLE.
REQ-018 Reset mid-window discards all partial state; the first cycle after reset accepts no sample.

Configuration
REQ-019 PARA_HIT_EN defined: THR registers and HIT counting present.
REQ-020 PARA_HIT_EN undefined: no THR/HIT logic; offsets 0x02, 0x03 and HIT offsets read 0x00 and ignore writes.

Structure
REQ-021 para_pkg holds register offset constants, the FSM state enum and the DW default.
REQ-022 One sub-module para_ch_acc (accumulator, min/max, hit, FSM), instantiated NCH times; para_stat holds the fx decode, CTRL/THR and the read mux.

Verification
REQ-023 NCH=4, WIN_LOG2=2, RUN=1, ch0 samples 10,20,30,40 -> 1 cycle later AVE=25, MIN=10, MAX=40; STATUS[7:4]=1.
REQ-024 THR=0x0015, ch1 samples 0x10,0x20,0x30,0x05 -> HIT=2 (PARA_HIT_EN); HIT reads 0 without the macro.
REQ-025 RUN=0 after 3 ch2 samples, then RUN=1 with 4 samples of 100 -> AVE=100; the partial window leaves no effect.
REQ-026 sm_ch=5 with NCH=4 -> no result or status change; dev_id mismatch on write -> CTRL unchanged; read -> fx_q=0x00.
REQ-027 Read AVE lo; a window end updates AVE from 0x0102 to 0x0304; then read AVE hi -> returns 0x01 (shadow).
REQ-028 CLR written in the same cycle as a window-end sample -> all results 0; rst asserted mid-window -> all registers 0, fx_q=0x00.

Source files
------------

// File: rtl/para_pkg.sv
// Shared constants for the para_stat statistics block: register offsets,
// result field selectors, the per-channel FSM state type and the DW default.
package para_pkg;

    localparam int DW_DEFAULT = 16;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h01;
    localparam logic [7:0] OFF_THR_LO   = 8'h02;
    localparam logic [7:0] OFF_THR_HI   = 8'h03;
    localparam logic [7:0] OFF_RES_BASE = 8'h10;

    // Result field index inside an 8-byte channel block (offset bits 2:1)
    localparam logic [1:0] FLD_AVE = 2'd0;
    localparam logic [1:0] FLD_MIN = 2'd1;
    localparam logic [1:0] FLD_MAX = 2'd2;
    localparam logic [1:0] FLD_HIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DUMP = 2'd2
    } ch_state_t;

endpackage

// File: rtl/para_ch_acc.sv
// One channel of windowed statistics: running sum, min, max and threshold hit
// count over 2^WIN_LOG2 samples. HIT logic exists only when PARA_HIT_EN is defined.
module para_ch_acc
    import para_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int WIN_LOG2 = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          run,
    input  logic          clr,
    input  logic          smp_vld,
    input  logic [DW-1:0] smp_data,
`ifdef PARA_HIT_EN
    input  logic [15:0]   thr,
    output logic [15:0]   hit,
`endif
    output logic [15:0]   ave,
    output logic [15:0]   min_val,
    output logic [15:0]   max_val,
    output logic          done
);
    localparam int SW = DW + WIN_LOG2;

    ch_state_t           state_reg, state_next;
    logic [WIN_LOG2-1:0] cnt_reg;
    logic [SW-1:0]       sum_reg, sum_next;
    logic [DW-1:0]       min_reg, min_next;
    logic [DW-1:0]       max_reg, max_next;
    logic [15:0]         ave_reg, min_res_reg, max_res_reg;
    logic                first_smp, last_smp;
`ifdef PARA_HIT_EN
    logic [15:0]         hit_acc_reg, hit_next, hit_res_reg;
`endif

    // The final sample is folded into the results on the same edge it is
    // accepted, so a sample during DUMP already starts the next window.
    always_comb begin
        first_smp = (cnt_reg == '0);
        last_smp  = smp_vld && (cnt_reg == '1);
        sum_next  = sum_reg + SW'(smp_data);
        min_next  = (first_smp || smp_data < min_reg) ? smp_data : min_reg;
        max_next  = (first_smp || smp_data > max_reg) ? smp_data : max_reg;
`ifdef PARA_HIT_EN
        hit_next  = hit_acc_reg;
        if (32'(smp_data) > 32'(thr) && hit_acc_reg != 16'hFFFF)
            hit_next = hit_acc_reg + 16'd1;
`endif
    end

    assign done = last_smp && !clr;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (run) state_next = ST_ACC;
            ST_ACC:  if (last_smp) state_next = ST_DUMP;
            ST_DUMP: state_next = ST_ACC;
            default: state_next = ST_IDLE;
        endcase
        if (clr && state_next == ST_DUMP) state_next = ST_ACC;
        if (!run) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_reg     <= '0;
            sum_reg     <= '0;
            min_reg     <= '0;
            max_reg     <= '0;
            ave_reg     <= '0;
            min_res_reg <= '0;
            max_res_reg <= '0;
`ifdef PARA_HIT_EN
            hit_acc_reg <= '0;
            hit_res_reg <= '0;
`endif
        end else if (!run) begin
            // Partial window is dropped; published results stay
            cnt_reg     <= '0;
            sum_reg     <= '0;
            min_reg     <= '0;
            max_reg     <= '0;
`ifdef PARA_HIT_EN
            hit_acc_reg <= '0;
`endif
        end else if (smp_vld) begin
            cnt_reg <= cnt_reg + WIN_LOG2'(1);
            if (last_smp) begin
                sum_reg     <= '0;
                min_reg     <= '0;
                max_reg     <= '0;
                ave_reg     <= 16'(sum_next >> WIN_LOG2);
                min_res_reg <= 16'(min_next);
                max_res_reg <= 16'(max_next);
`ifdef PARA_HIT_EN
                hit_acc_reg <= '0;
                hit_res_reg <= hit_next;
`endif
            end else begin
                sum_reg     <= sum_next;
                min_reg     <= min_next;
                max_reg     <= max_next;
`ifdef PARA_HIT_EN
                hit_acc_reg <= hit_next;
`endif
            end
        end
    end

    assign ave     = ave_reg;
    assign min_val = min_res_reg;
    assign max_val = max_res_reg;
`ifdef PARA_HIT_EN
    assign hit     = hit_res_reg;
`endif

endmodule

// File: rtl/para_stat.sv
// Multi-channel windowed statistics with a byte-wide register port.
// Define PARA_HIT_EN to build the THR registers and per-channel HIT counters.
module para_stat
    import para_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DW       = DW_DEFAULT,
    parameter int WIN_LOG2 = 8
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [DW-1:0] sm_data,
    input  logic [2:0]    sm_ch,
    input  logic          sm_vld,
    input  logic          fx_wr,
    input  logic [21:0]   fx_waddr,
    input  logic [7:0]    fx_data,
    input  logic          fx_rd,
    input  logic [21:0]   fx_raddr,
    output logic [7:0]    fx_q,
    input  logic [5:0]    dev_id
);
    logic                  run_reg;
    logic [3:0]            done_cnt_reg;
    logic [7:0]            fx_q_reg;
    logic [7:0]            shadow_reg;
    logic [7:0]            shadow_off_reg;
    logic                  shadow_vld_reg;
    logic                  wr_hit, rd_hit, clr;
    logic [7:0]            wr_off, rd_off;
    logic [3:0]            rd_ch;
    logic                  rd_in_range, rd_is_res, rd_sh_hit;
    logic [15:0]           rd_field;
    logic [7:0]            rd_val;
    logic [NCH-1:0]        done_vec;
    logic [NCH-1:0][15:0]  res_ave, res_min, res_max;
`ifdef PARA_HIT_EN
    logic [15:0]           thr_reg;
    logic [NCH-1:0][15:0]  res_hit;
`endif
    logic                  unused_bits;

    assign unused_bits = ^{fx_waddr[15:8], fx_raddr[15:8], fx_data[7:2]};

    assign wr_hit = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rd_hit = fx_rd && (fx_raddr[21:16] == dev_id);
    assign wr_off = fx_waddr[7:0];
    assign rd_off = fx_raddr[7:0];
    // Combinational so the clear lands on the write edge and beats a window end
    assign clr    = wr_hit && (wr_off == OFF_CTRL) && fx_data[1];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic acc_vld;
        assign acc_vld = sm_vld && run_reg && (sm_ch == 3'(gi));

        para_ch_acc #(
            .DW       (DW),
            .WIN_LOG2 (WIN_LOG2)
        ) u_acc (
            .clk      (clk_sys),
            .srst     (rst),
            .run      (run_reg),
            .clr      (clr),
            .smp_vld  (acc_vld),
            .smp_data (sm_data),
`ifdef PARA_HIT_EN
            .thr      (thr_reg),
            .hit      (res_hit[gi]),
`endif
            .ave      (res_ave[gi]),
            .min_val  (res_min[gi]),
            .max_val  (res_max[gi]),
            .done     (done_vec[gi])
        );
    end

    always_comb begin
        rd_field    = 16'h0000;
        rd_ch       = rd_off[6:3] - 4'd2;
        rd_in_range = (rd_off >= OFF_RES_BASE) && (rd_off < 8'(16 + 8 * NCH));
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == 4'(i)) begin
                case (rd_off[2:1])
                    FLD_AVE: rd_field = res_ave[i];
                    FLD_MIN: rd_field = res_min[i];
                    FLD_MAX: rd_field = res_max[i];
`ifdef PARA_HIT_EN
                    FLD_HIT: rd_field = res_hit[i];
`endif
                    default: rd_field = 16'h0000;
                endcase
            end
        end
`ifdef PARA_HIT_EN
        rd_is_res = rd_in_range;
`else
        rd_is_res = rd_in_range && (rd_off[2:1] != FLD_HIT);
`endif
        rd_sh_hit = rd_off[0] && shadow_vld_reg && (shadow_off_reg == {rd_off[7:1], 1'b0});

        rd_val = 8'h00;
        case (rd_off)
            OFF_CTRL:   rd_val = {7'd0, run_reg};
            OFF_STATUS: rd_val = {done_cnt_reg, 3'd0, run_reg};
`ifdef PARA_HIT_EN
            OFF_THR_LO: rd_val = thr_reg[7:0];
            OFF_THR_HI: rd_val = thr_reg[15:8];
`endif
            default: begin
                if (rd_is_res)
                    rd_val = !rd_off[0] ? rd_field[7:0]
                           : (rd_sh_hit ? shadow_reg : rd_field[15:8]);
            end
        endcase
        if (!rd_hit) rd_val = 8'h00;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            run_reg        <= 1'b0;
            done_cnt_reg   <= 4'd0;
            fx_q_reg       <= 8'h00;
            shadow_reg     <= 8'h00;
            shadow_off_reg <= 8'h00;
            shadow_vld_reg <= 1'b0;
`ifdef PARA_HIT_EN
            thr_reg        <= 16'h0000;
`endif
        end else begin
            if (wr_hit && wr_off == OFF_CTRL) run_reg <= fx_data[0];
`ifdef PARA_HIT_EN
            if (wr_hit && wr_off == OFF_THR_LO) thr_reg[7:0]  <= fx_data;
            if (wr_hit && wr_off == OFF_THR_HI) thr_reg[15:8] <= fx_data;
`endif
            if (clr)
                done_cnt_reg <= 4'd0;
            else if (|done_vec)
                done_cnt_reg <= done_cnt_reg + 4'd1;

            if (fx_rd) begin
                fx_q_reg <= rd_val;
                // A lo read snapshots its hi byte; the matching hi read consumes it
                if (rd_hit && rd_is_res && !rd_off[0]) begin
                    shadow_reg     <= rd_field[15:8];
                    shadow_off_reg <= rd_off;
                    shadow_vld_reg <= 1'b1;
                end else if (rd_hit && rd_is_res && rd_sh_hit) begin
                    shadow_vld_reg <= 1'b0;
                end
            end
        end
    end

    assign fx_q = fx_q_reg;

endmodule

// File: tb/tb_para_stat.sv
// Self-checking bench for para_stat: window-level reference model compared
// against fx_q every cycle, plus directed literal checks.
module tb_para_stat;
    localparam int NCH = 4;
    localparam int DW = 16;
    localparam int WL = 2;
    localparam int WIN = 4;
    localparam logic [5:0] DEV = 6'h2A;
    localparam logic [5:0] BAD = 6'h15;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sm_data = '0;
    logic [2:0]  sm_ch = '0;
    logic        sm_vld = 1'b0;
    logic        fx_wr = 1'b0;
    logic [21:0] fx_waddr = '0;
    logic [7:0]  fx_data = '0;
    logic        fx_rd = 1'b0;
    logic [21:0] fx_raddr = '0;
    logic [7:0]  fx_q;
    logic [5:0]  dev_id = DEV;

    int checks = 0;
    int errors = 0;

    para_stat #(.NCH(NCH), .DW(DW), .WIN_LOG2(WL)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .sm_data  (sm_data),
        .sm_ch    (sm_ch),
        .sm_vld   (sm_vld),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .dev_id   (dev_id)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    bit          started = 1'b0;
    bit          m_run;
    logic [15:0] m_thr;
    int          m_done;
    logic [7:0]  m_q;
    bit          m_sh_vld;
    int          m_sh_off;
    logic [7:0]  m_sh;
    int          win_n [NCH];
    int unsigned win_smp [NCH][WIN];
    bit          win_hit [NCH][WIN];
    logic [15:0] m_res [NCH][4];

    function automatic bit field_exists(input int f);
`ifdef PARA_HIT_EN
        return 1'b1;
`else
        return f != 3;
`endif
    endfunction

    function automatic bit is_result(input int o);
        return o >= 16 && o < 16 + 8 * NCH && field_exists(((o - 16) % 8) / 2);
    endfunction

    function automatic logic [7:0] model_read(input int o);
        int c, k;
        logic [15:0] v;
        if (o == 0) return {7'd0, m_run};
        if (o == 1) return {4'(m_done % 16), 3'd0, m_run};
`ifdef PARA_HIT_EN
        if (o == 2) return m_thr[7:0];
        if (o == 3) return m_thr[15:8];
`endif
        if (!is_result(o)) return 8'h00;
        c = (o - 16) / 8;
        k = (o - 16) % 8;
        v = m_res[c][k / 2];
        if (k % 2 == 0) return v[7:0];
        if (m_sh_vld && m_sh_off == o - 1) return m_sh;
        return v[15:8];
    endfunction

    task automatic model_clear_windows();
        for (int c = 0; c < NCH; c++) win_n[c] = 0;
    endtask

    task automatic model_reset();
        m_run = 0; m_thr = 0; m_done = 0; m_q = 0;
        m_sh_vld = 0; m_sh_off = 0; m_sh = 0;
        model_clear_windows();
        for (int c = 0; c < NCH; c++)
            for (int f = 0; f < 4; f++) m_res[c][f] = 16'h0;
    endtask

    task automatic model_finish_window(input int c);
        longint unsigned sum;
        int unsigned mn, mx, h;
        sum = 0; mn = 32'hFFFF_FFFF; mx = 0; h = 0;
        for (int i = 0; i < WIN; i++) begin
            sum += win_smp[c][i];
            if (win_smp[c][i] < mn) mn = win_smp[c][i];
            if (win_smp[c][i] > mx) mx = win_smp[c][i];
            if (win_hit[c][i]) h++;
        end
        m_res[c][0] = 16'(sum / WIN);
        m_res[c][1] = 16'(mn);
        m_res[c][2] = 16'(mx);
        m_res[c][3] = field_exists(3) ? 16'((h > 65535) ? 65535 : h) : 16'h0;
        win_n[c] = 0;
        m_done++;
    endtask

    always @(posedge clk_sys) begin : model_blk
        int ro, wo, c;
        bit rd_dec, wr_dec, clr;
        logic [7:0] rv;
        started = 1'b1;
        if (rst) begin
            model_reset();
        end else begin
            rd_dec = fx_rd && fx_raddr[21:16] == dev_id;
            wr_dec = fx_wr && fx_waddr[21:16] == dev_id;
            ro = int'(fx_raddr[7:0]);
            wo = int'(fx_waddr[7:0]);
            if (fx_rd) begin
                rv = rd_dec ? model_read(ro) : 8'h00;
                if (rd_dec && is_result(ro) && ro % 2 == 0) begin
                    m_sh = m_res[(ro - 16) / 8][((ro - 16) % 8) / 2][15:8];
                    m_sh_off = ro;
                    m_sh_vld = 1;
                end else if (rd_dec && is_result(ro) && m_sh_vld && m_sh_off == ro - 1) begin
                    m_sh_vld = 0;
                end
                m_q = rv;
            end
            clr = wr_dec && wo == 0 && fx_data[1];
            c = int'(sm_ch);
            if (clr) begin
                model_clear_windows();
                for (int i = 0; i < NCH; i++)
                    for (int f = 0; f < 4; f++) m_res[i][f] = 16'h0;
                m_done = 0;
            end else if (!m_run) begin
                model_clear_windows();
            end else if (sm_vld && c < NCH) begin
                win_smp[c][win_n[c]] = sm_data;
                win_hit[c][win_n[c]] = sm_data > m_thr;
                win_n[c]++;
                if (win_n[c] == WIN) model_finish_window(c);
            end
            if (wr_dec && wo == 0) m_run = fx_data[0];
`ifdef PARA_HIT_EN
            if (wr_dec && wo == 2) m_thr[7:0] = fx_data;
            if (wr_dec && wo == 3) m_thr[15:8] = fx_data;
`endif
        end
    end

    // Every-cycle comparison of the registered read port
    always @(negedge clk_sys) begin
        if (started) begin
            checks++;
            if (fx_q !== m_q) begin
                errors++;
                $display("FAIL fx_q_cycle t=%0t got=%02h exp=%02h", $time, fx_q, m_q);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
        sm_vld = 1'b0; fx_wr = 1'b0; fx_rd = 1'b0;
    endtask

    task automatic smp(input int c, input int d);
        sm_vld = 1'b1; sm_ch = 3'(c); sm_data = 16'(d);
        step();
    endtask

    task automatic wr(input logic [5:0] d, input logic [7:0] off, input logic [7:0] v);
        fx_wr = 1'b1; fx_waddr = {d, 8'h5A, off}; fx_data = v;
        step();
        $display("wr dev=%02h off=%02h data=%02h", d, off, v);
    endtask

    task automatic rd_chk(input string name, input logic [5:0] d, input logic [7:0] off,
                          input logic [7:0] exp);
        fx_rd = 1'b1; fx_raddr = {d, 8'hA5, off};
        step();
        $display("rd %s dev=%02h off=%02h q=%02h", name, d, off, fx_q);
        check(name, fx_q, exp);
        check({name, "_model"}, m_q, exp);
    endtask

    initial begin
        int lo_pend;
        int r, off;
        logic [7:0] hit_exp;
`ifdef PARA_HIT_EN
        hit_exp = 8'd2;
`else
        hit_exp = 8'd0;
`endif
        @(negedge clk_sys);
        repeat (3) step();
        rst = 1'b0;
        smp(0, 77);                       // first cycle after reset: not accepted
        rd_chk("ctrl_rst", DEV, 8'h00, 8'h00);
        rd_chk("status_rst", DEV, 8'h01, 8'h00);
        rd_chk("ave0_rst", DEV, 8'h10, 8'h00);

        // Basic window on ch0
        wr(DEV, 8'h00, 8'h01);
        smp(0, 10); smp(0, 20); smp(0, 30); smp(0, 40);
        rd_chk("ave0_lo", DEV, 8'h10, 8'd25);
        rd_chk("ave0_hi", DEV, 8'h11, 8'd0);
        rd_chk("min0_lo", DEV, 8'h12, 8'd10);
        rd_chk("max0_lo", DEV, 8'h14, 8'd40);
        rd_chk("status_1", DEV, 8'h01, 8'h11);

        // Threshold hits on ch1
        wr(DEV, 8'h02, 8'h15);
        wr(DEV, 8'h03, 8'h00);
        smp(1, 8'h10); smp(1, 8'h20); smp(1, 8'h30); smp(1, 8'h05);
        rd_chk("hit1_lo", DEV, 8'h1E, hit_exp);
        rd_chk("min1_lo", DEV, 8'h1A, 8'h05);
        rd_chk("max1_lo", DEV, 8'h1C, 8'h30);

        // Partial window discarded by RUN=0
        smp(2, 7); smp(2, 7); smp(2, 7);
        wr(DEV, 8'h00, 8'h00);
        wr(DEV, 8'h00, 8'h01);
        smp(2, 100); smp(2, 100); smp(2, 100); smp(2, 100);
        rd_chk("ave2_lo", DEV, 8'h20, 8'd100);
        rd_chk("min2_lo", DEV, 8'h22, 8'd100);
        rd_chk("status_3", DEV, 8'h01, 8'h31);

        // Out-of-range channel and foreign device select
        smp(5, 999); smp(5, 999); smp(5, 999); smp(5, 999);
        rd_chk("status_ch5", DEV, 8'h01, 8'h31);
        wr(BAD, 8'h00, 8'h00);
        rd_chk("ctrl_baddev", DEV, 8'h00, 8'h01);
        rd_chk("rd_baddev", BAD, 8'h00, 8'h00);
        rd_chk("undecoded", DEV, 8'h05, 8'h00);

        // Tear-free lo/hi read across a window end
        smp(3, 16'h0102); smp(3, 16'h0102); smp(3, 16'h0102); smp(3, 16'h0102);
        rd_chk("ave3_lo_a", DEV, 8'h28, 8'h02);
        smp(3, 16'h0304); smp(3, 16'h0304); smp(3, 16'h0304); smp(3, 16'h0304);
        rd_chk("ave3_hi_shadow", DEV, 8'h29, 8'h01);
        rd_chk("ave3_lo_b", DEV, 8'h28, 8'h04);
        rd_chk("ave3_hi_b", DEV, 8'h29, 8'h03);
        rd_chk("max3_hi_live", DEV, 8'h2D, 8'h03);

        // CLR in the same cycle as a window-ending sample
        smp(0, 5); smp(0, 5); smp(0, 5);
        sm_vld = 1'b1; sm_ch = 3'd0; sm_data = 16'd5;
        fx_wr = 1'b1; fx_waddr = {DEV, 8'h00, 8'h00}; fx_data = 8'h03;
        step();
        rd_chk("ave0_clr", DEV, 8'h10, 8'h00);
        rd_chk("max1_clr", DEV, 8'h1C, 8'h00);
        rd_chk("status_clr", DEV, 8'h01, 8'h01);
        smp(0, 9); smp(0, 9); smp(0, 9); smp(0, 9);
        rd_chk("ave0_after_clr", DEV, 8'h10, 8'd9);

        // Randomized traffic, checked every cycle against the model
        lo_pend = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sm_vld = ($urandom % 3) != 0;
            sm_ch = 3'($urandom % 6);
            sm_data = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 63));
            if ($urandom % 40 == 0) begin
                r = $urandom % 8;
                fx_wr = 1'b1;
                fx_waddr = {DEV, 8'($urandom), 8'h00};
                fx_data = {6'($urandom), ($urandom % 8) == 0, ($urandom % 8) != 0};
                if (r == 4) begin fx_waddr[7:0] = 8'h02; fx_data = 8'($urandom_range(0, 63)); end
                if (r == 5) begin fx_waddr[7:0] = 8'h03; fx_data = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00; end
                if (r == 6) begin fx_waddr[7:0] = 8'($urandom_range(4, 95)); fx_data = 8'($urandom); end
                if (r == 7) begin fx_waddr[21:16] = BAD; fx_data = 8'h00; end
            end
            if ($urandom % 2 == 0) begin
                if (lo_pend >= 0 && $urandom % 2 == 0) off = lo_pend + 1;
                else off = int'($urandom_range(0, 95));
                lo_pend = (off >= 16 && off % 2 == 0) ? off : -1;
                fx_rd = 1'b1;
                fx_raddr = {($urandom % 10 == 0) ? BAD : DEV, 8'($urandom), 8'(off)};
            end
            step();
        end

        // Reset in the middle of a window
        wr(DEV, 8'h00, 8'h01);
        smp(0, 50); smp(0, 50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("fx_q_after_rst", fx_q, 8'h00);
        smp(0, 50);
        rd_chk("ctrl_mid_rst", DEV, 8'h00, 8'h00);
        rd_chk("status_mid_rst", DEV, 8'h01, 8'h00);
        rd_chk("thr_mid_rst", DEV, 8'h02, 8'h00);
        rd_chk("ave3_mid_rst", DEV, 8'h28, 8'h00);
        wr(DEV, 8'h00, 8'h01);
        smp(0, 8); smp(0, 8); smp(0, 8); smp(0, 8);
        rd_chk("ave0_post_rst", DEV, 8'h10, 8'd8);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
